dice_roll_sequencer: RTL

- Controller that sequences a multi-die roll (N dice of one type, plus modifier) over an external free-running random source.
- Requests one random word per cycle, uses rejection sampling to remove modulo bias, accumulates the faces, and presents a held result with a busy/valid handshake to the seven-segment display path.
- Sits between the DIP/mode inputs and the display block, replacing direct modulo rolling.

---
 rtl/dice_roll_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/dice_roll_sequencer.sv
// Multi-die roll sequencer: spin animation, rejection-sampled draws, held result.
// Optional ADVANTAGE_EN macro adds adv_mode (keep higher/lower of two d20).
module dice_roll_sequencer #(
  parameter int SPIN_CYCLES = 16,
  parameter int MAX_RETRIES = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic [2:0] dice_type,
  input  logic [2:0] num_dice,
  input  logic [4:0] modifier,
  input  logic [7:0] rng_value,
`ifdef ADVANTAGE_EN
  input  logic [1:0] adv_mode,
`endif
  output logic       rng_step,
  output logic       busy,
  output logic       result_valid,
  output logic [7:0] result,
  output logic [2:0] die_index,
  output logic [4:0] die_face,
  output logic       crit
);

  localparam int SW = $clog2(SPIN_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    DRAW,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    type_q, type_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [4:0]    mod_q, mod_d;
  logic [1:0]    adv_q, adv_d;
  logic [SW-1:0] spin_q, spin_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    sum_q, sum_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    face_q, face_d;
  logic          step_q, step_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [7:0]    result_q, result_d;
  logic          crit_q, crit_d;

  logic [4:0] sides;
  logic [4:0] mask;
  logic [4:0] m;
  logic       fixed;
  logic       accept;
  logic [4:0] draw_face;
  logic [4:0] kept;
  logic       rng_unused;

  // Upper random bits are never needed: the widest die uses five bits.
  assign rng_unused = ^rng_value[7:5];

  // Die geometry and the accept/reject decision for the current draw.
  always_comb begin
    sides     = 5'd1;
    mask      = 5'h00;
    fixed     = 1'b0;
    accept    = 1'b0;
    draw_face = 5'd1;
    unique case (type_q)
      3'd0: begin sides = 5'd4;  mask = 5'h03; end
      3'd1: begin sides = 5'd6;  mask = 5'h07; end
      3'd2: begin sides = 5'd8;  mask = 5'h07; end
      3'd3: begin sides = 5'd10; mask = 5'h0F; end
      3'd4: begin sides = 5'd12; mask = 5'h0F; end
      3'd5: begin sides = 5'd20; mask = 5'h1F; end
      default: fixed = 1'b1;
    endcase
    m = rng_value[4:0] & mask;
    if (fixed) begin
      accept    = 1'b1;
      draw_face = 5'd1;
    end else if (m < sides) begin
      accept    = 1'b1;
      draw_face = m + 5'd1;
    end else if (retry_q == RW'(MAX_RETRIES)) begin
      // m < 2*sides for every die, so one subtraction is the modulo.
      accept    = 1'b1;
      draw_face = 5'(m - sides + 5'd1);
    end
  end

  // Face kept across the two advantage draws.
  always_comb begin
    kept = draw_face;
    if (idx_q != 3'd0) begin
      if (adv_q == 2'd1) begin
        kept = (draw_face > sum_q[4:0]) ? draw_face : sum_q[4:0];
      end else begin
        kept = (draw_face < sum_q[4:0]) ? draw_face : sum_q[4:0];
      end
    end
  end

  // Next-state and registered-output logic for the roll controller.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    cnt_d    = cnt_q;
    mod_d    = mod_q;
    adv_d    = adv_q;
    spin_d   = spin_q;
    retry_d  = retry_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    face_d   = face_q;
    valid_d  = valid_q;
    result_d = result_q;
    crit_d   = crit_q;
    unique case (state_q)
      IDLE: begin
        if (roll_req) begin
          type_d  = dice_type;
          cnt_d   = (num_dice == 3'd0) ? 4'd8 : {1'b0, num_dice};
          mod_d   = modifier;
          adv_d   = 2'd0;
`ifdef ADVANTAGE_EN
          if (dice_type == 3'd5 &&
              (adv_mode == 2'd1 || adv_mode == 2'd2)) begin
            adv_d = adv_mode;
            cnt_d = 4'd2;
          end
`endif
          sum_d   = 8'd0;
          idx_d   = 3'd0;
          retry_d = '0;
          spin_d  = '0;
          crit_d  = 1'b0;
          valid_d = 1'b0;
          state_d = SPIN;
        end
      end
      SPIN: begin
        face_d = (rng_value[4:0] & mask) + 5'd1;
        if (spin_q == SW'(SPIN_CYCLES - 1)) begin
          state_d = DRAW;
        end else begin
          spin_d = spin_q + 1'b1;
        end
      end
      DRAW: begin
        if (accept) begin
          face_d  = draw_face;
          retry_d = '0;
          if (adv_q != 2'd0) begin
            sum_d = {3'd0, kept};
          end else begin
            sum_d = sum_q + {3'd0, draw_face};
          end
          if ({1'b0, idx_q} == cnt_q - 4'd1) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end
      DONE: begin
        result_d = sum_q + {3'd0, mod_q};
        valid_d  = 1'b1;
        if (adv_q != 2'd0) begin
          crit_d = (sum_q == 8'd20);
        end else begin
          crit_d = (cnt_q == 4'd1) && (type_q == 3'd5) &&
                   (face_q == 5'd20);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    step_d = (state_d == SPIN) || (state_d == DRAW);
    busy_d = step_d || (state_d == DONE);
  end

  // State and output registers; reset aborts any roll in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      type_q   <= 3'd0;
      cnt_q    <= 4'd1;
      mod_q    <= 5'd0;
      adv_q    <= 2'd0;
      spin_q   <= '0;
      retry_q  <= '0;
      sum_q    <= 8'd0;
      idx_q    <= 3'd0;
      face_q   <= 5'd0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= 8'd0;
      crit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      cnt_q    <= cnt_d;
      mod_q    <= mod_d;
      adv_q    <= adv_d;
      spin_q   <= spin_d;
      retry_q  <= retry_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      face_q   <= face_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      crit_q   <= crit_d;
    end
  end

  assign rng_step     = step_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign die_index    = idx_q;
  assign die_face     = face_q;
  assign crit         = crit_q;

endmodule
